countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Two-digit countdown timer: tens digit `ds`, units digit `us`.
- Consumes the per-bit preset/clear vectors produced by the timer-preset encoder, qualified by the `pls` load strobe.
- Loads the selected time, then counts down one unit per `tick` under `start`/`pause` control, and flags expiry.
- Sits between the preset encoder and the display/alarm logic.

Parameters:
- DIGIT_W, 2, width of each digit register.
- US_MAX, 3, value the units digit wraps to on borrow. Legal range 1..2^DIGIT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pls  input  1  load strobe; qualifies the preset/clear vectors.
- psDS  input  DIGIT_W  per-bit preset for the tens digit.
- clDS  input  DIGIT_W  per-bit clear for the tens digit.
- psUS  input  DIGIT_W  per-bit preset for the units digit.
- clUS  input  DIGIT_W  per-bit clear for the units digit.
- tick  input  1  count enable, one-cycle pulse per time unit.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- ds  output  DIGIT_W  current tens digit.
- us  output  DIGIT_W  current units digit.
- running  output  1  high while in RUN.
- zero  output  1  high when ds==0 and us==0.
- done  output  1  one-cycle pulse on expiry.
- err  output  1  sticky flag: a load saw preset and clear both set on the same bit.

Behaviour:
- Reset (rst_n low, asynchronous, any state): ds=0, us=0, state=IDLE, running=0, done=0, err=0. `zero` is combinational, so it reads 1.
- All other updates happen on the rising edge of clk. Deassertion of rst_n is synchronised externally.
- Load, per bit, when pls=1 at the edge:
  - ps=1, cl=0 -> bit=1.
  - ps=0, cl=1 -> bit=0.
  - ps=0, cl=0 -> bit holds.
  - ps=1, cl=1 -> bit=0 and err set.
- Load takes one cycle; new digits are visible in the next cycle.
- pls has the highest priority: in any state it loads, forces the state to IDLE, suppresses tick/start/pause that cycle, and never pulses done.
- err clears only on reset or on a subsequent error-free load.
- States: IDLE, RUN, PAUSED, DONE.
- IDLE:
  - start with zero=0 -> RUN.
  - start with zero=1 -> DONE, with done pulsed the next cycle.
  - tick ignored.
- RUN:
  - pause=1 -> PAUSED. pause beats a same-cycle tick; no decrement.
  - Else tick=1 -> decrement.
  - If the decrement takes the value from ds=0,us=1 to 0 -> DONE; done=1 for exactly the cycle after that edge.
  - start while already in RUN is ignored.
- PAUSED:
  - start=1 and pause=0 -> RUN. Resuming is not immediate: ticks count again only from the edge after the one where RUN is entered.
  - Ticks in PAUSED are dropped.
  - start and pause together -> stay PAUSED.
- DONE:
  - Holds ds=us=0. tick, start and pause are ignored.
  - Exits only on pls (-> IDLE) or reset.
- Decrement:
  - us>0 -> us=us-1.
  - Else us=US_MAX and ds=ds-1.
  - Never below zero: a tick at zero has no effect.
- Loaded units values above US_MAX are accepted as-is; counting proceeds from them normally.
- running=1 exactly when state==RUN. done is registered; at most one pulse per expiry.

Test Plan:
- Reset mid-count: load ds=2,us=1, start, 3 ticks, assert rst_n=0 -> ds=0, us=0, running=0, zero=1 immediately without a clock edge.
- Load decode:
  - psDS=10, clDS=01, psUS=01, clUS=10, pls -> ds=2, us=1, err=0.
  - Then pls with psUS=11, clUS=11 -> us=0, err=1.
  - Then a clean load -> err=0.
- Full countdown, default params: ds=1,us=0, start, 4 ticks -> sequence 1:0, 0:3, 0:2, 0:1, 0:0; done high one cycle after the 4th tick edge; state DONE; a 5th tick leaves 0:0.
- Pause priority: in RUN at 0:3, pause and tick in the same cycle -> value stays 0:3, PAUSED.
  - 2 ticks while paused -> still 0:3.
  - start, then tick -> 0:2.
- Start at zero: IDLE with ds=us=0, start -> DONE, single done pulse, running never 1.
- Load preempts: in RUN at 0:2, pls with tick and start in the same cycle -> loaded value, state IDLE, no decrement, no done pulse.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Bus bundle between the preset encoder / control side and the countdown timer.
// The master drives the load vectors and controls; the slave returns digits and status.
interface countdown_timer_if #(
    parameter int DIGIT_W = 2
);
    logic               pls;
    logic [DIGIT_W-1:0] psDS;
    logic [DIGIT_W-1:0] clDS;
    logic [DIGIT_W-1:0] psUS;
    logic [DIGIT_W-1:0] clUS;
    logic               tick;
    logic               start;
    logic               pause;
    logic [DIGIT_W-1:0] ds;
    logic [DIGIT_W-1:0] us;
    logic               running;
    logic               zero;
    logic               done;
    logic               err;

    modport master (
        output pls, psDS, clDS, psUS, clUS, tick, start, pause,
        input  ds, us, running, zero, done, err
    );

    modport slave (
        input  pls, psDS, clDS, psUS, clUS, tick, start, pause,
        output ds, us, running, zero, done, err
    );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit countdown timer: per-bit preset/clear load, tick-driven decrement
// with start/pause control, a one-cycle done pulse and a sticky load-error flag.
module countdown_timer #(
    parameter int DIGIT_W = 2,
    parameter int US_MAX  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic [DIGIT_W-1:0] ds_r;
    logic [DIGIT_W-1:0] us_r;
    logic               running_r;
    logic               done_r;
    logic               err_r;
    logic               zero_s;
    logic               lastUnit_s;
    logic               loadErr_s;

    // A conflicting preset+clear bit resolves to 0; no request holds the bit.
    function automatic logic [DIGIT_W-1:0] applyLoad(
        input logic [DIGIT_W-1:0] cur,
        input logic [DIGIT_W-1:0] ps,
        input logic [DIGIT_W-1:0] cl
    );
        return (ps & ~cl) | (cur & ~ps & ~cl);
    endfunction

    assign zero_s     = (ds_r == {DIGIT_W{1'b0}}) && (us_r == {DIGIT_W{1'b0}});
    assign lastUnit_s = (ds_r == {DIGIT_W{1'b0}}) && (us_r == DIGIT_W'(1));
    assign loadErr_s  = (|(bus.psDS & bus.clDS)) || (|(bus.psUS & bus.clUS));

    assign bus.ds      = ds_r;
    assign bus.us      = us_r;
    assign bus.running = running_r;
    assign bus.zero    = zero_s;
    assign bus.done    = done_r;
    assign bus.err     = err_r;

    // Control FSM, digit registers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ds_r      <= {DIGIT_W{1'b0}};
            us_r      <= {DIGIT_W{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.pls) begin
                ds_r      <= applyLoad(ds_r, bus.psDS, bus.clDS);
                us_r      <= applyLoad(us_r, bus.psUS, bus.clUS);
                err_r     <= loadErr_s;
                state_r   <= IDLE;
                running_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.start && zero_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else if (bus.start) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state_r   <= PAUSED;
                            running_r <= 1'b0;
                        end else if (bus.tick && !zero_s) begin
                            if (us_r != {DIGIT_W{1'b0}}) begin
                                us_r <= us_r - DIGIT_W'(1);
                            end else begin
                                us_r <= DIGIT_W'(US_MAX);
                                ds_r <= ds_r - DIGIT_W'(1);
                            end
                            // Expiry is detected on the value before the final decrement.
                            if (lastUnit_s) begin
                                state_r   <= DONE;
                                running_r <= 1'b0;
                                done_r    <= 1'b1;
                            end else begin
                                state_r <= RUN;
                            end
                        end else begin
                            state_r <= RUN;
                        end
                    end
                    PAUSED: begin
                        if (bus.start && !bus.pause) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r <= PAUSED;
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    default: begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_countdown_timer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   cycCnt;

    countdown_timer_if #(.DIGIT_W(2)) bus ();

    countdown_timer #(.DIGIT_W(2), .US_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int       cyc;
        logic [7:0] val;
        string    name;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycCnt <= cycCnt + 1;

    function automatic logic [7:0] actual();
        return {bus.ds, bus.us, bus.running, bus.zero, bus.done, bus.err};
    endfunction

    task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got ds,us,run,zero,done,err=%b want %b", nm, act, want);
        end
    endtask

    // Monitor: check each queued expectation once its target edge has passed.
    always @(negedge clk) begin
        if (rst_n && expQ.size() > 0 && expQ[0].cyc <= cycCnt) begin
            monE = expQ.pop_front();
            compare(monE.name, actual(), monE.val);
        end
    end

    task automatic step(
        input logic p, input logic [1:0] pD, input logic [1:0] cD,
        input logic [1:0] pU, input logic [1:0] cU,
        input logic t, input logic s, input logic pa,
        input logic [1:0] eD, input logic [1:0] eU,
        input logic eR, input logic eDn, input logic eE, input string nm
    );
        exp_t x;
        bus.pls = p; bus.psDS = pD; bus.clDS = cD; bus.psUS = pU; bus.clUS = cU;
        bus.tick = t; bus.start = s; bus.pause = pa;
        x.cyc  = cycCnt + 1;
        x.val  = {eD, eU, eR, (eD == 2'd0 && eU == 2'd0), eDn, eE};
        x.name = nm;
        expQ.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cycCnt = 0;
        bus.pls = 1'b0; bus.psDS = 2'b00; bus.clDS = 2'b00; bus.psUS = 2'b00; bus.clUS = 2'b00;
        bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 compare("reset_state", actual(), 8'b00_00_0_1_0_0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   pls psDS   clDS   psUS   clUS  tick start pause  ds    us   run done err
        step(1'b1, 2'b10, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, "load_decode");
        step(1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, "load_conflict");
        step(1'b1, 2'b01, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, "load_clean");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, "idle_tick");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, "start_run");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, "tick_borrow");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, "tick_0_2");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, "tick_0_1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "expire_done");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "tick_at_zero");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "done_ign_start");
        step(1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, "load_0_3");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, "start_0_3");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, "pause_beats_tick");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, "paused_tick1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, "paused_tick2");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, "start_and_pause");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, "resume_no_dec");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, "resume_tick");
        step(1'b1, 2'b10, 2'b01, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, "load_preempts");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, "preempt_idle");
        step(1'b1, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "load_zero");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "start_at_zero");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "zero_done_once");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, "zero_start_again");
        step(1'b1, 2'b10, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, "load_2_1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, "start_2_1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, "tick_2_0");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0, "tick_1_3");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, "tick_1_2");
        drain();

        // Asynchronous reset mid-count, checked before any clock edge.
        rst_n = 1'b0;
        #2 compare("reset_mid_count", actual(), 8'b00_00_0_1_0_0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, 2'b00, 2'b11, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, "load_0_1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, "start_0_1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "expire_0_1");
        step(1'b1, 2'b01, 2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, "load_exits_done");
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, "idle_hold");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
